shift_rows_pipe: RTL

Registered, parametrised Rijndael ShiftRows / InvShiftRows engine with valid/ready handshakes on both sides. Each transaction carries a per-block direction bit and is processed with one-cycle latency. Block width is 4·NB bytes, covering the Rijndael block sizes NB = 4, 6 and 8. The block sits between the SubBytes/InvSubBytes stage and the MixColumns/AddRoundKey stage of the round datapath, and replaces the fixed 128-bit combinational inverse permutation.

---
 rtl/shift_rows_pkg.sv | 31 +++
 rtl/shift_rows_perm.sv | 29 ++
 rtl/shift_rows_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/shift_rows_pkg.sv
// Shared definitions for the ShiftRows / InvShiftRows engine:
// legal column counts, row offset table and buffer occupancy states.
package shift_rows_pkg;

    // Rijndael block sizes supported by the engine (columns per state)
    localparam int NB_LEGAL_N = 3;
    localparam logic [NB_LEGAL_N-1:0][7:0] NB_LEGAL = {8'd8, 8'd6, 8'd4};

    // Output buffer occupancy; TWO is only reachable with the skid entry
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    function automatic bit nb_is_legal(input int nb);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < NB_LEGAL_N; i++) begin
            if (int'(NB_LEGAL[i]) == nb) ok = 1'b1;
        end
        return ok;
    endfunction

    // Row shift amounts: 0,1,2,3 for NB=4/6 and 0,1,3,4 for NB=8
    function automatic int row_off(input int nb, input int r);
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational forward / inverse Rijndael row rotation.
// Ports: din (state in), inv (1 = InvShiftRows), dout (permuted state).
// State byte n sits at bits [8(4NB-1-n) +: 8]; row = n mod 4, col = n div 4.
module shift_rows_perm
    import shift_rows_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] din,
    input  logic             inv,
    output logic [32*NB-1:0] dout
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int OFF   = row_off(NB, r);
            // forward pulls from the right, inverse from the left
            localparam int COL_F = (c + OFF) % NB;
            localparam int COL_I = (c + NB - OFF) % NB;
            localparam int DST   = 32*NB - 8 - 8*(4*c + r);
            localparam int SRC_F = 32*NB - 8 - 8*(4*COL_F + r);
            localparam int SRC_I = 32*NB - 8 - 8*(4*COL_I + r);

            assign dout[DST +: 8] = inv ? din[SRC_I +: 8]
                                        : din[SRC_F +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage with valid/ready on both sides.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_inv/din
// upstream; out_valid/out_ready/dout/out_inv downstream; blk_cnt counts
// delivered blocks (wraps). Macro SHIFTROWS_SKID_EN adds a skid entry and
// makes in_ready a flop; otherwise a single register with in_ready
// combinational from out_ready.
module shift_rows_pipe
    import shift_rows_pkg::*;
#(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [32*NB-1:0]   din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [32*NB-1:0]   dout,
    output logic               out_inv,
    output logic [CNT_W-1:0]   blk_cnt
);

    localparam int W = 32*NB;

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0] perm_data;
    logic [W:0]   new_e;
    logic         in_xfer;
    logic         out_xfer;

    occ_e             state_q, state_d;
    logic [W:0]       head_q, head_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .din  (din),
        .inv  (in_inv),
        .dout (perm_data)
    );

    // stored entry: {permuted data, direction}
    assign new_e     = {perm_data, in_inv};
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign dout      = head_q[W:1];
    assign out_inv   = head_q[0];
    assign blk_cnt   = cnt_q;

`ifdef SHIFTROWS_SKID_EN
    logic [W:0] skid_q, skid_d;
    logic       in_rdy_q;

    assign in_ready = in_rdy_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
`ifdef SHIFTROWS_SKID_EN
        skid_d  = skid_q;
`endif
        cnt_d   = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    head_d  = new_e;
                end
            end
            ONE: begin
                if (in_xfer) begin
                    // accept + drain: new block replaces head
                    if (out_xfer) head_d = new_e;
`ifdef SHIFTROWS_SKID_EN
                    else begin
                        state_d = TWO;
                        skid_d  = new_e;
                    end
`endif
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
`ifdef SHIFTROWS_SKID_EN
            TWO: begin
                // in_ready is low here, so only a drain can happen
                if (out_xfer) begin
                    state_d = ONE;
                    head_d  = skid_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SHIFTROWS_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q   <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            skid_q   <= skid_d;
            in_rdy_q <= (state_d != TWO);
        end
    end
`endif

endmodule
